// File: rtl/des_loader_pkg.sv
// Shared types and sizing helpers for the DES block loader.
package des_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic bit is_legal_word_w(input int w);
        return (w == 16) || (w == 32) || (w == 64);
    endfunction

    function automatic int words_per_field(input int w);
        return 64 / w;
    endfunction

    function automatic int frame_words(input int w);
        return 2 * (64 / w);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/des_frame_assembler.sv
// Collects key then plaintext words into a 128-bit frame buffer and flags when it is full.
module des_frame_assembler
    import des_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_valid_din,
    input  logic [0:WORD_W-1] word_din,
    input  logic              take_i,
    output logic              word_ready_dout,
    output logic              frame_full_o,
    output logic              partial_o,
    output logic [0:63]       key_buf_o,
    output logic [0:63]       pt_buf_o
);

    localparam int WPB = words_per_field(WORD_W);
    localparam int NW  = frame_words(WORD_W);
    localparam int CW  = cnt_width(NW);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic [0:63]   key_q, key_d;
    logic [0:63]   pt_q, pt_d;
    logic          accept_s;

    assign accept_s        = word_valid_din && !full_q;
    assign word_ready_dout = !full_q;
    assign frame_full_o    = full_q;
    assign partial_o       = (cnt_q != '0);
    assign key_buf_o       = key_q;
    assign pt_buf_o        = pt_q;

    // Word placement, counter wrap and full flag; take only happens while full, so it never meets an accept.
    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        key_d  = key_q;
        pt_d   = pt_q;
        if (take_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (accept_s) begin
            if (int'(cnt_q) < WPB) begin
                key_d[int'(cnt_q) * WORD_W +: WORD_W] = word_din;
            end else begin
                pt_d[(int'(cnt_q) - WPB) * WORD_W +: WORD_W] = word_din;
            end
            if (cnt_q == CW'(NW - 1)) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            key_q  <= '0;
            pt_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            key_q  <= key_d;
            pt_q   <= pt_d;
        end
    end

endmodule

// File: rtl/des_block_loader.sv
// Feeds (key, plaintext) blocks to des_core: frame assembly, hold register, issue FSM and watchdog.
module des_block_loader
    import des_loader_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_valid_din,
    input  logic [0:WORD_W-1] word_din,
    output logic              word_ready_dout,
    input  logic              active_des_engine_din,
    input  logic              done_strobe_din,
    output logic              start_strobe_dout,
    output logic [0:63]       plaintext_dout,
    output logic [0:63]       key_dout,
    output logic              loader_busy_dout,
    output logic              timeout_err_dout
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READY = READY;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam int         WD_W     = cnt_width(TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic            strobe_q, strobe_d;
    logic [0:63]     key_hold_q, key_hold_d;
    logic [0:63]     pt_hold_q, pt_hold_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    logic            frame_full_s;
    logic            partial_s;
    logic            transfer_s;
    logic            expire_s;
    logic [0:63]     key_buf_s;
    logic [0:63]     pt_buf_s;

    assign transfer_s = frame_full_s && (state_q == ST_IDLE);
    assign expire_s   = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

    des_frame_assembler #(
        .WORD_W (WORD_W)
    ) u_asm (
        .clk             (clk),
        .reset           (reset),
        .word_valid_din  (word_valid_din),
        .word_din        (word_din),
        .take_i          (transfer_s),
        .word_ready_dout (word_ready_dout),
        .frame_full_o    (frame_full_s),
        .partial_o       (partial_s),
        .key_buf_o       (key_buf_s),
        .pt_buf_o        (pt_buf_s)
    );

    // Issue FSM: a non-IDLE state means the hold register owns a block.
    always_comb begin
        state_d    = state_q;
        strobe_d   = 1'b0;
        key_hold_d = key_hold_q;
        pt_hold_d  = pt_hold_q;
        wd_d       = wd_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer_s) begin
                    state_d    = ST_READY;
                    key_hold_d = key_buf_s;
                    pt_hold_d  = pt_buf_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READY: begin
                if (!active_des_engine_din) begin
                    state_d  = ST_RUN;
                    strobe_d = 1'b1;
                    wd_d     = '0;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_RUN: begin
                // done takes priority so a completion on the expiry edge is not flagged.
                if (done_strobe_din) begin
                    state_d = ST_IDLE;
                end else if (expire_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Issue state, hold register, watchdog and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            strobe_q   <= 1'b0;
            key_hold_q <= '0;
            pt_hold_q  <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            strobe_q   <= strobe_d;
            key_hold_q <= key_hold_d;
            pt_hold_q  <= pt_hold_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
        end
    end

    assign start_strobe_dout = strobe_q;
    assign key_dout          = key_hold_q;
    assign plaintext_dout    = pt_hold_q;
    assign timeout_err_dout  = err_q;
    assign loader_busy_dout  = partial_s || frame_full_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_des_block_loader.sv
// Scoreboard bench for des_block_loader with a simple des_core stand-in.
module tb_des_block_loader;

    localparam int WORD_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int WPB     = 64 / WORD_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          word_valid;
    logic [31:0]   word;
    logic          word_ready;
    logic          active;
    logic          done_auto;
    logic          done_man;
    logic          done_s;
    logic          strobe;
    logic [63:0]   pt;
    logic [63:0]   key;
    logic          busy;
    logic          err;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [127:0]  exp_q[$];
    bit            auto_done = 1'b1;
    logic [31:0]   fw[2*WPB];
    logic [63:0]   key_a;

    assign done_s = done_auto | done_man;

    always #5 clk = ~clk;

    des_block_loader #(
        .WORD_W  (WORD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .word_valid_din        (word_valid),
        .word_din              (word),
        .word_ready_dout       (word_ready),
        .active_des_engine_din (active),
        .done_strobe_din       (done_s),
        .start_strobe_dout     (strobe),
        .plaintext_dout        (pt),
        .key_dout              (key),
        .loader_busy_dout      (busy),
        .timeout_err_dout      (err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every start strobe must be a single-cycle pulse carrying the oldest expected block.
    initial begin : monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (strobe === 1'b1) begin
                check("strobe_one_cycle", {127'd0, prev}, 128'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: actual key %0h pt %0h required no strobe", key, pt);
                end else begin
                    check("block_key_pt", {key, pt}, exp_q.pop_front());
                end
            end
            prev = strobe;
        end
    end

    // Engine stand-in: answers each strobe with done after 1..TIMEOUT cycles.
    initial begin : engine
        int cd;
        cd = 0;
        done_auto = 1'b0;
        forever begin
            @(negedge clk);
            done_auto = 1'b0;
            if (reset) begin
                cd = 0;
            end else begin
                if (strobe && auto_done) cd = $urandom_range(TIMEOUT, 1);
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) done_auto = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1, "simulation time limit");
    end

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        word_valid = 1'b1;
        word = w;
        while (!word_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_word_ready_wait: actual ready %0b required 1", word_ready);
        end
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic send_frame(input bit issue, input int gap_max);
        logic [63:0] k;
        logic [63:0] p;
        k = 64'd0;
        p = 64'd0;
        for (int i = 0; i < WPB; i++) k = (k << WORD_W) | 64'(fw[i]);
        for (int i = 0; i < WPB; i++) p = (p << WORD_W) | 64'(fw[WPB + i]);
        if (issue) exp_q.push_back({k, p});
        for (int i = 0; i < 2 * WPB; i++) begin
            send_word(fw[i]);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 2 * WPB; i++) fw[i] = $urandom;
    endtask

    task automatic pulse_done();
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: actual busy %0b pending %0d required idle", busy, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int saw;
        reset      = 1'b1;
        word_valid = 1'b0;
        word       = 32'd0;
        active     = 1'b0;
        done_man   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", {127'd0, word_ready}, 128'd1);
        check("reset_outputs", {strobe, busy, err, key, pt}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame and latency.
        fw[0] = 32'h13345779; fw[1] = 32'h9BBCDFF1;
        fw[2] = 32'h01234567; fw[3] = 32'h89ABCDEF;
        send_frame(1'b1, 0);
        check("basic_no_strobe_n", {127'd0, strobe}, 128'd0);
        @(negedge clk);
        check("basic_key", {64'd0, key}, {64'd0, 64'h133457799BBCDFF1});
        check("basic_pt", {64'd0, pt}, {64'd0, 64'h0123456789ABCDEF});
        check("basic_no_strobe_n1", {127'd0, strobe}, 128'd0);
        @(negedge clk);
        check("basic_strobe_n2", {127'd0, strobe}, 128'd1);
        wait_idle();

        // Back-pressure: second frame streams while the first block runs.
        auto_done = 1'b0;
        rand_frame();
        send_frame(1'b1, 0);
        key_a = {fw[0], fw[1]};
        repeat (2) @(negedge clk);
        check("bp_first_strobe", {127'd0, strobe}, 128'd1);
        rand_frame();
        send_frame(1'b1, 0);
        check("bp_ready_low", {127'd0, word_ready}, 128'd0);
        check("bp_hold_stable", {64'd0, key}, {64'd0, key_a});
        pulse_done();
        check("bp_hold_after_done", {64'd0, key}, {64'd0, key_a});
        check("bp_no_strobe_d1", {127'd0, strobe}, 128'd0);
        @(negedge clk);
        check("bp_hold_loaded", {64'd0, key}, {64'd0, fw[0], fw[1]});
        check("bp_ready_back", {127'd0, word_ready}, 128'd1);
        @(negedge clk);
        check("bp_second_strobe", {127'd0, strobe}, 128'd1);
        pulse_done();
        auto_done = 1'b1;
        wait_idle();

        // Engine busy holds the block in READY.
        active = 1'b1;
        rand_frame();
        send_frame(1'b1, 0);
        saw = 0;
        repeat (10) begin
            @(negedge clk);
            if (strobe) saw++;
        end
        check("busy_no_strobe", 128'(saw), 128'd0);
        active = 1'b0;
        @(negedge clk);
        check("busy_strobe_after_release", {127'd0, strobe}, 128'd1);
        wait_idle();

        // Done on the watchdog expiry edge wins.
        auto_done = 1'b0;
        rand_frame();
        send_frame(1'b1, 0);
        repeat (2) @(negedge clk);
        check("tie_strobe", {127'd0, strobe}, 128'd1);
        repeat (TIMEOUT - 1) @(negedge clk);
        pulse_done();
        check("tie_no_error", {127'd0, err}, 128'd0);
        check("tie_idle", {127'd0, busy}, 128'd0);

        // Spurious done while idle.
        pulse_done();
        @(negedge clk);
        check("spurious_state", {busy, err, word_ready}, 128'd1);

        // Watchdog expiry.
        rand_frame();
        send_frame(1'b1, 0);
        repeat (2) @(negedge clk);
        check("wd_strobe", {127'd0, strobe}, 128'd1);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("wd_err_early", {127'd0, err}, 128'd0);
        @(negedge clk);
        check("wd_err_set", {127'd0, err}, 128'd1);
        check("wd_back_idle", {127'd0, busy}, 128'd0);
        auto_done = 1'b1;
        rand_frame();
        send_frame(1'b1, 0);
        wait_idle();
        check("wd_err_sticky", {127'd0, err}, 128'd1);

        // Reset mid-frame discards everything.
        rand_frame();
        send_word(fw[0]);
        send_word(fw[1]);
        reset = 1'b1;
        #1;
        check("rst_mid_ready", {127'd0, word_ready}, 128'd1);
        check("rst_mid_outputs", {strobe, busy, err, key, pt}, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rand_frame();
        send_frame(1'b1, 0);
        wait_idle();

        // Randomized traffic with random word gaps and engine latency.
        for (int f = 0; f < 20; f++) begin
            rand_frame();
            send_frame(1'b1, 2);
        end
        wait_idle();
        check("rand_no_error", {127'd0, err}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
